// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake plus the data-memory bus of mem_access_unit
interface mem_access_unit_if;
   logic        req_valid, req_ready, req_rw, req_signed;
   logic [1:0]  req_size;
   logic [7:0]  req_address;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_ready, resp_error;
   logic [31:0] resp_rdata;
   logic [7:0]  ram_address;
   logic [31:0] ram_data_in, ram_data_out;
   logic [1:0]  ram_size;
   logic        ram_rw, ram_enable;
   modport slave (
      input  req_valid, req_rw, req_size, req_signed, req_address, req_wdata, resp_ready, ram_data_out,
      output req_ready, resp_valid, resp_rdata, resp_error, ram_address, ram_data_in, ram_size, ram_rw, ram_enable
   );
   modport master (
      output req_valid, req_rw, req_size, req_signed, req_address, req_wdata, resp_ready, ram_data_out,
      input  req_ready, resp_valid, resp_rdata, resp_error, ram_address, ram_data_in, ram_size, ram_rw, ram_enable
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: big-endian byte/halfword/word load-store unit over a byte/word data memory
module mem_access_unit (
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
   state_t      r_state, w_next;
   logic        r_rw, r_signed, r_err;
   logic [1:0]  r_size;
   logic [7:0]  r_addr;
   logic [31:0] r_wdata, r_rdata;
   logic        w_illegal, w_accept, w_acc, w_wr;
   function automatic logic [31:0] ext(input logic [15:0] v, input logic half, input logic sgn);
      return half ? {{16{sgn & v[15]}}, v} : {{24{sgn & v[7]}}, v[7:0]};
   endfunction
   assign w_illegal = (bus.req_size == 2'b11) || (bus.req_size == 2'b01 && bus.req_address[0]) ||
                      (bus.req_size == 2'b10 && bus.req_address[1:0] != 2'b00);
   assign w_accept  = r_state == IDLE && bus.req_valid;
   // gating with rst_n keeps a reset cycle from issuing one more RAM access
   assign w_acc     = rst_n && (r_state == ACC1 || r_state == ACC2);
   assign w_wr      = w_acc && r_rw;
   always_ff @(posedge clk)
      r_state <= !rst_n ? IDLE : w_next;
   always_comb begin
      w_next = r_state == IDLE ? (bus.req_valid ? (w_illegal ? RESP : ACC1) : IDLE)
             : r_state == ACC1 ? (r_size == 2'b01 ? ACC2 : RESP)
             : r_state == ACC2 ? RESP
             : (bus.resp_ready ? IDLE : RESP);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rw     <= 1'b0;
         r_signed <= 1'b0;
         r_size   <= 2'b00;
         r_addr   <= 8'h00;
         r_wdata  <= 32'h0;
         r_rdata  <= 32'h0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_rw     <= bus.req_rw;
         r_signed <= bus.req_signed;
         r_size   <= bus.req_size;
         r_addr   <= bus.req_address;
         r_wdata  <= bus.req_wdata;
         r_rdata  <= 32'h0;
         r_err    <= w_illegal;
      end else if (r_state == ACC1 && !r_rw) begin
         // halfword keeps the high byte raw until the second access completes it
         r_rdata  <= r_size == 2'b10 ? bus.ram_data_out
                   : r_size == 2'b01 ? {24'h0, bus.ram_data_out[7:0]}
                   : ext({8'h0, bus.ram_data_out[7:0]}, 1'b0, r_signed);
      end else if (r_state == ACC2 && !r_rw) begin
         r_rdata  <= ext({r_rdata[7:0], bus.ram_data_out[7:0]}, 1'b1, r_signed);
      end
   end
   always_comb begin
      bus.req_ready   = r_state == IDLE;
      bus.resp_valid  = r_state == RESP;
      bus.resp_rdata  = r_rdata;
      bus.resp_error  = r_err;
      bus.ram_enable  = w_acc;
      bus.ram_rw      = w_wr;
      bus.ram_size    = {1'b0, w_acc && r_size == 2'b10};
      bus.ram_address = !w_acc ? 8'h00 : r_state == ACC2 ? r_addr + 8'd1 : r_addr;
      bus.ram_data_in = !w_wr ? 32'h0
                      : r_size == 2'b10 ? r_wdata
                      : {24'h0, (r_state == ACC1 && r_size == 2'b01) ? r_wdata[15:8] : r_wdata[7:0]};
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table vectors, hand corner sequences and random traffic against a byte-array model
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst_n;
   logic load_en;
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] acc_q [$];
   int n_cmp = 0;
   int n_bad = 0;
   mem_access_unit_if bus ();
   mem_access_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always_comb bus.ram_data_out = bus.ram_size[0]
      ? {mem[bus.ram_address], mem[bus.ram_address + 8'd1], mem[bus.ram_address + 8'd2], mem[bus.ram_address + 8'd3]}
      : {24'h0, mem[bus.ram_address]};
   always @(posedge clk) begin
      if (load_en) mem <= ref_mem;
      else if (bus.ram_enable && bus.ram_rw) begin
         if (bus.ram_size[0]) for (int i = 0; i < 4; i++) mem[bus.ram_address + 8'(i)] <= bus.ram_data_in[8*(3-i) +: 8];
         else mem[bus.ram_address] <= bus.ram_data_in[7:0];
      end
   end
   typedef struct {
      logic rw; logic [1:0] sz; logic sg; logic [7:0] a; logic [31:0] wd;
      logic [31:0] rd; logic er; int lat;
   } vec_t;
   vec_t tbl [17];
   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", nm, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic sync_mem();
      load_en = 1'b1;
      step();
      load_en = 1'b0;
   endtask
   // reference: a request is a run of 1/2/4 big-endian bytes at an aligned address
   task automatic ref_txn(input logic rw, input logic [1:0] sz, input logic sg, input logic [7:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int nacc);
      int nb;
      nb   = 1 << sz;
      er   = sz == 2'd3 || (int'(a) % nb) != 0;
      rd   = 32'h0;
      lat  = er ? 1 : (sz == 2'd1 ? 3 : 2);
      nacc = er ? 0 : (sz == 2'd1 ? 2 : 1);
      if (!er) for (int i = 0; i < nb; i++) begin
         if (rw) ref_mem[8'(int'(a) + i)] = wd[8*(nb-1-i) +: 8];
         else rd = {rd[23:0], ref_mem[8'(int'(a) + i)]};
      end
      if (!er && !rw && sg && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFFFFFF << (8*nb));
   endtask
   task automatic run(input logic rw, input logic [1:0] sz, input logic sg, input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
      int n = 0;
      bus.req_rw = rw; bus.req_size = sz; bus.req_signed = sg; bus.req_address = a; bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      while (!bus.req_ready && n < 10) begin step(); n++; end
      step();
      bus.req_valid = 1'b0;
      bus.req_rw = 1'($urandom); bus.req_size = 2'($urandom); bus.req_signed = 1'($urandom);
      bus.req_address = 8'($urandom); bus.req_wdata = $urandom;
      acc_q.delete();
      lat = 1;
      while (!bus.resp_valid && lat < 8) begin
         if (bus.ram_enable) acc_q.push_back(bus.ram_address);
         step();
         lat++;
      end
      rd = bus.resp_rdata;
      er = bus.resp_error;
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
   endtask
   task automatic verify(input string tg, input logic [7:0] a, input logic [31:0] rd, input logic [31:0] erd,
                         input logic er, input logic eer, input int lat, input int elat, input int enacc);
      check({tg, "_rdata"}, rd, erd);
      check({tg, "_error"}, 32'(er), 32'(eer));
      check({tg, "_latency"}, 32'(lat), 32'(elat));
      check({tg, "_accesses"}, 32'(acc_q.size()), 32'(enacc));
      if (enacc > 0 && acc_q.size() > 0) check({tg, "_addr0"}, 32'(acc_q[0]), 32'(a));
      if (enacc == 2 && acc_q.size() > 1) check({tg, "_addr1"}, 32'(acc_q[1]), 32'(a + 8'd1));
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [31:0] rd, erd, wd;
      logic er, eer, rw, sg;
      logic [1:0] sz;
      logic [7:0] a;
      int lat, elat, enacc;
      tbl = '{
         '{1'b0, 2'd2, 1'b0, 8'h00, 32'h0,        32'h12345678, 1'b0, 2},
         '{1'b0, 2'd1, 1'b1, 8'h04, 32'h0,        32'hFFFFF00F, 1'b0, 3},
         '{1'b0, 2'd1, 1'b0, 8'h04, 32'h0,        32'h0000F00F, 1'b0, 3},
         '{1'b1, 2'd0, 1'b0, 8'h02, 32'h111111A6, 32'h0,        1'b0, 2},
         '{1'b0, 2'd0, 1'b1, 8'h02, 32'h0,        32'hFFFFFFA6, 1'b0, 2},
         '{1'b0, 2'd0, 1'b0, 8'h02, 32'h0,        32'h000000A6, 1'b0, 2},
         '{1'b1, 2'd1, 1'b0, 8'h08, 32'h5555DDEE, 32'h0,        1'b0, 3},
         '{1'b0, 2'd2, 1'b0, 8'h08, 32'h0,        32'hDDEE0000, 1'b0, 2},
         '{1'b0, 2'd0, 1'b0, 8'h09, 32'h0,        32'h000000EE, 1'b0, 2},
         '{1'b0, 2'd2, 1'b0, 8'h06, 32'h0,        32'h0,        1'b1, 1},
         '{1'b0, 2'd1, 1'b0, 8'h03, 32'h0,        32'h0,        1'b1, 1},
         '{1'b0, 2'd3, 1'b0, 8'h00, 32'h0,        32'h0,        1'b1, 1},
         '{1'b1, 2'd2, 1'b0, 8'h0C, 32'hCAFEBABE, 32'h0,        1'b0, 2},
         '{1'b0, 2'd1, 1'b1, 8'h0E, 32'h0,        32'hFFFFBABE, 1'b0, 3},
         '{1'b0, 2'd0, 1'b1, 8'h01, 32'h0,        32'h00000034, 1'b0, 2},
         '{1'b1, 2'd2, 1'b0, 8'h05, 32'hDEADBEEF, 32'h0,        1'b1, 1},
         '{1'b0, 2'd1, 1'b0, 8'h04, 32'h0,        32'h0000F00F, 1'b0, 3}
      };
      rst_n = 1'b0; load_en = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
      bus.req_rw = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0; bus.req_address = 8'h0; bus.req_wdata = 32'h0;
      repeat (3) step();
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp", {bus.resp_error, bus.resp_rdata[30:0]}, 32'd0);
      check("rst_ram_ctl", {21'h0, bus.ram_enable, bus.ram_rw, bus.ram_size, bus.ram_address}, 32'd0);
      check("rst_ram_din", bus.ram_data_in, 32'd0);
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
      ref_mem[0] = 8'h12; ref_mem[1] = 8'h34; ref_mem[2] = 8'h56; ref_mem[3] = 8'h78;
      ref_mem[4] = 8'hF0; ref_mem[5] = 8'h0F;
      for (int i = 8; i < 12; i++) ref_mem[i] = 8'h00;
      sync_mem();
      rst_n = 1'b1;
      step();
      for (int v = 0; v < 17; v++) begin
         ref_txn(tbl[v].rw, tbl[v].sz, tbl[v].sg, tbl[v].a, tbl[v].wd, erd, eer, elat, enacc);
         run(tbl[v].rw, tbl[v].sz, tbl[v].sg, tbl[v].a, tbl[v].wd, rd, er, lat);
         verify($sformatf("vec%0d", v), tbl[v].a, rd, tbl[v].rd, er, tbl[v].er, lat, tbl[v].lat, enacc);
      end
      // response stall with req_valid held high and garbage fields while busy
      bus.req_rw = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0; bus.req_address = 8'h00; bus.req_valid = 1'b1;
      step();
      bus.req_size = 2'd3; bus.req_address = 8'h55;
      step();
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", 32'(bus.resp_valid), 32'd1);
         check("stall_rdata", bus.resp_rdata, 32'h1234A678);
         check("stall_req_ready", 32'(bus.req_ready), 32'd0);
         step();
      end
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      check("release_req_ready", 32'(bus.req_ready), 32'd1);
      check("release_no_accept", 32'(bus.resp_valid), 32'd0);
      bus.req_valid = 1'b0;
      step();
      for (int k = 0; k < 300; k++) begin
         rw = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom); wd = $urandom;
         a = 8'($urandom_range(64, 95));
         if ($urandom_range(0, 3) != 0) a = a & (sz == 2'd2 ? 8'hFC : sz == 2'd1 ? 8'hFE : 8'hFF);
         ref_txn(rw, sz, sg, a, wd, erd, eer, elat, enacc);
         run(rw, sz, sg, a, wd, rd, er, lat);
         verify($sformatf("rnd%0d", k), a, rd, erd, er, eer, lat, elat, enacc);
         repeat ($urandom_range(0, 2)) step();
      end
      // reset while the second byte of a halfword store is on the bus
      ref_mem[8'h20] = 8'hAA; ref_mem[8'h21] = 8'hBB;
      sync_mem();
      bus.req_rw = 1'b1; bus.req_size = 2'd1; bus.req_address = 8'h20; bus.req_wdata = 32'h00001234; bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      check("acc1_addr", {24'h0, bus.ram_address}, 32'h20);
      check("acc1_din", bus.ram_data_in, 32'h12);
      step();
      check("acc2_addr", {24'h0, bus.ram_address}, 32'h21);
      check("acc2_din", bus.ram_data_in, 32'h34);
      rst_n = 1'b0;
      step();
      check("mid_rst_ram", {bus.ram_enable, bus.ram_rw, 22'h0, bus.ram_address}, 32'd0);
      check("mid_rst_din", bus.ram_data_in, 32'd0);
      check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      check("mid_rst_resp", 32'(bus.resp_valid), 32'd0);
      check("mid_rst_mem20", {24'h0, mem[8'h20]}, 32'h12);
      check("mid_rst_mem21", {24'h0, mem[8'h21]}, 32'hBB);
      ref_mem[8'h20] = 8'h12;
      rst_n = 1'b1;
      step();
      step();
      check("post_rst_resp", 32'(bus.resp_valid), 32'd0);
      for (int i = 0; i < 256; i++) check($sformatf("mem%0d", i), {24'h0, mem[i]}, {24'h0, ref_mem[i]});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
